// File: rtl/tlb_walk_ctrl_pkg.sv
// Shared definitions for the TLB walk controller: page width default,
// offset width default and the controller state encoding.
`ifndef PAGE_WIDTH
`define PAGE_WIDTH 4
`endif

package tlb_walk_ctrl_pkg;

    localparam int DEFAULT_PAGE_WIDTH   = `PAGE_WIDTH;
    localparam int DEFAULT_OFFSET_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WALK   = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4
    } walk_state_e;

endpackage

// File: rtl/walk_timer.sv
// Page-walk latency counter: loaded with the walk delay, counts down one
// step per enabled cycle and flags the final walk cycle (count == 1).
module walk_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    // Count register: load has priority, decrement saturates at zero.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/tlb_walk_ctrl.sv
// TLB miss handler: looks the request page up in the TLB, walks for a fixed
// latency on a miss, fills the TLB with the walked translation and retries.
// Page 0 is unmapped and yields a fault response after the walk.
module tlb_walk_ctrl
    import tlb_walk_ctrl_pkg::*;
#(
    parameter int PAGE_WIDTH       = `PAGE_WIDTH,
    parameter int OFFSET_WIDTH     = DEFAULT_OFFSET_WIDTH,
    parameter int WALK_DELAY       = 4,
    parameter int WALK_DELAY_WIDTH = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    // request channel
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [PAGE_WIDTH+OFFSET_WIDTH-1:0] req_vaddr,
    input  logic                               flush,
    // TLB lookup port
    output logic [PAGE_WIDTH-1:0]              tlb_vpage,
    output logic                               tlb_valid,
    input  logic                               tlb_hit,
    input  logic [PAGE_WIDTH-1:0]              tlb_ppage,
    input  logic                               tlb_exception,
    // TLB fill port
    output logic                               fill_valid,
    output logic [PAGE_WIDTH-1:0]              fill_vpage,
    output logic [PAGE_WIDTH-1:0]              fill_ppage,
    // response channel
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [PAGE_WIDTH+OFFSET_WIDTH-1:0] resp_paddr,
    output logic                               resp_exception
);

    localparam int AW = PAGE_WIDTH + OFFSET_WIDTH;

    walk_state_e           state_q;
    walk_state_e           state_d;
    logic [AW-1:0]         vaddr_q;
    logic [AW-1:0]         paddr_q;
    logic                  exception_q;

    logic                  capture_req;
    logic                  capture_hit;
    logic                  capture_fault;
    logic                  timer_load;
    logic                  timer_dec;
    logic                  walk_done;

    logic [PAGE_WIDTH-1:0]   vpage;
    logic [OFFSET_WIDTH-1:0] offset;

    assign vpage  = vaddr_q[AW-1:OFFSET_WIDTH];
    assign offset = vaddr_q[OFFSET_WIDTH-1:0];

    walk_timer #(
        .WIDTH (WALK_DELAY_WIDTH)
    ) u_walk_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (WALK_DELAY_WIDTH'(WALK_DELAY)),
        .dec        (timer_dec),
        .done       (walk_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; flush aborts only the in-flight states.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        capture_req   = 1'b0;
        capture_hit   = 1'b0;
        capture_fault = 1'b0;
        timer_load    = 1'b0;
        timer_dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture_req = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (tlb_hit) begin
                    capture_hit = 1'b1;
                    state_d     = RESP;
                end else begin
                    // A repeated miss after our own fill simply walks again.
                    timer_load = 1'b1;
                    state_d    = WALK;
                end
            end
            WALK: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    timer_dec = 1'b1;
                    if (walk_done) begin
                        if (vpage != '0) begin
                            state_d = FILL;
                        end else begin
                            capture_fault = 1'b1;
                            state_d       = RESP;
                        end
                    end
                end
            end
            FILL: begin
                state_d = flush ? IDLE : LOOKUP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request address and response registers.
    // NOTE: every datapath register is reset so that outputs derived from
    // them read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr_q     <= '0;
            paddr_q     <= '0;
            exception_q <= 1'b0;
        end else begin
            if (capture_req) begin
                vaddr_q <= req_vaddr;
            end
            if (capture_hit) begin
                paddr_q     <= {tlb_ppage, offset};
                exception_q <= tlb_exception;
            end else if (capture_fault) begin
                paddr_q     <= '0;
                exception_q <= 1'b1;
            end
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign tlb_valid      = (state_q == LOOKUP);
    assign tlb_vpage      = vpage;
    assign fill_valid     = (state_q == FILL) && !flush;
    assign fill_vpage     = vpage;
    assign fill_ppage     = vpage + PAGE_WIDTH'(1);
    assign resp_valid     = (state_q == RESP);
    assign resp_paddr     = paddr_q;
    assign resp_exception = exception_q;

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
// Directed bench for tlb_walk_ctrl: a vector table of single translations
// plus hand sequences for flush, back-pressure, reset and re-walk cases.
// Cycle c is the clock period after the c-th edge following the cycle in
// which the request is presented (cycle 0).
`timescale 1ns/1ps
module tb_tlb_walk_ctrl;

    localparam int PW = 4;
    localparam int OW = 12;
    localparam int AW = PW + OW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_vaddr = '0;
    logic          flush = 1'b0;
    logic [PW-1:0] tlb_vpage;
    logic          tlb_valid;
    logic          tlb_hit;
    logic [PW-1:0] tlb_ppage;
    logic          tlb_exception;
    logic          fill_valid;
    logic [PW-1:0] fill_vpage;
    logic [PW-1:0] fill_ppage;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [AW-1:0] resp_paddr;
    logic          resp_exception;

    int tests = 0;
    int fails = 0;

    // Reference TLB: direct-mapped by virtual page, written only by the
    // stimulus process (preloads, and fills when fill_en is set).
    logic          tlb_v  [16];
    logic [PW-1:0] tlb_pp [16];
    logic          tlb_ex [16];
    logic          fill_en = 1'b1;

    assign tlb_hit       = tlb_v[tlb_vpage];
    assign tlb_ppage     = tlb_pp[tlb_vpage];
    assign tlb_exception = tlb_ex[tlb_vpage];

    always #5 clk = ~clk;

    tlb_walk_ctrl #(
        .PAGE_WIDTH       (PW),
        .OFFSET_WIDTH     (OW),
        .WALK_DELAY       (4),
        .WALK_DELAY_WIDTH (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_vaddr      (req_vaddr),
        .flush          (flush),
        .tlb_vpage      (tlb_vpage),
        .tlb_valid      (tlb_valid),
        .tlb_hit        (tlb_hit),
        .tlb_ppage      (tlb_ppage),
        .tlb_exception  (tlb_exception),
        .fill_valid     (fill_valid),
        .fill_vpage     (fill_vpage),
        .fill_ppage     (fill_ppage),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_paddr     (resp_paddr),
        .resp_exception (resp_exception)
    );

    typedef struct {
        logic [AW-1:0] vaddr;
        logic          pre_valid;
        logic [PW-1:0] pre_vp;
        logic [PW-1:0] pre_pp;
        logic          pre_ex;
        int            exp_lat;
        logic [AW-1:0] exp_paddr;
        logic          exp_exc;
        int            exp_fills;
        logic [PW-1:0] exp_fvp;
        logic [PW-1:0] exp_fpp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_tlb();
        for (int i = 0; i < 16; i++) begin
            tlb_v[i]  = 1'b0;
            tlb_pp[i] = '0;
            tlb_ex[i] = 1'b0;
        end
    endtask

    // Advance into the next cycle and drive inputs shortly after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in cycle 0.
    task automatic present(input logic [AW-1:0] va);
        step();
        req_valid = 1'b1;
        req_vaddr = va;
    endtask

    // Run one translation with resp_ready=1; report latency and fill activity.
    task automatic run_txn(input logic [AW-1:0] va, output int lat,
                           output logic [AW-1:0] pa, output logic exc,
                           output int fills, output logic [PW-1:0] fvp,
                           output logic [PW-1:0] fpp, output logic ready0);
        bit got = 0;
        lat = -1; pa = '0; exc = 1'b0; fills = 0; fvp = '0; fpp = '0;
        present(va);
        @(negedge clk);
        ready0 = req_ready;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            req_valid = 1'b0;
            @(negedge clk);
            if (fill_valid) begin
                fills++;
                fvp = fill_vpage;
                fpp = fill_ppage;
                if (fill_en) begin
                    tlb_v[fill_vpage]  = 1'b1;
                    tlb_pp[fill_vpage] = fill_ppage;
                    tlb_ex[fill_vpage] = 1'b0;
                end
            end
            if (resp_valid) begin
                got = 1;
                lat = c;
                pa  = resp_paddr;
                exc = resp_exception;
            end
        end
    endtask

    initial begin
        int            lat;
        int            fills;
        logic [AW-1:0] pa;
        logic          exc;
        logic [PW-1:0] fvp;
        logic [PW-1:0] fpp;
        logic          rdy;
        bit            saw_fill;
        bit            saw_resp;
        int            fill_c [2];

        vecs[0] = '{16'h5ABC, 1'b1, 4'h5, 4'h6, 1'b0, 2, 16'h6ABC, 1'b0, 0, 4'h0, 4'h0};
        vecs[1] = '{16'h7123, 1'b0, 4'h0, 4'h0, 1'b0, 8, 16'h8123, 1'b0, 1, 4'h7, 4'h8};
        vecs[2] = '{16'h0010, 1'b0, 4'h0, 4'h0, 1'b0, 6, 16'h0000, 1'b1, 0, 4'h0, 4'h0};
        vecs[3] = '{16'hF001, 1'b0, 4'h0, 4'h0, 1'b0, 8, 16'h0001, 1'b0, 1, 4'hF, 4'h0};
        vecs[4] = '{16'h3FFF, 1'b1, 4'h3, 4'hA, 1'b1, 2, 16'hAFFF, 1'b1, 0, 4'h0, 4'h0};
        vecs[5] = '{16'h0FFF, 1'b1, 4'h0, 4'hC, 1'b0, 2, 16'hCFFF, 1'b0, 0, 4'h0, 4'h0};
        vecs[6] = '{16'h1000, 1'b0, 4'h0, 4'h0, 1'b0, 8, 16'h2000, 1'b0, 1, 4'h1, 4'h2};

        clear_tlb();

        // Reset values while rst_n is low.
        @(negedge clk);
        @(negedge clk);
        check("rst req_ready", req_ready, 1);
        check("rst tlb_valid", tlb_valid, 0);
        check("rst fill_valid", fill_valid, 0);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_exception", resp_exception, 0);
        check("rst resp_paddr", resp_paddr, 0);
        check("rst tlb_vpage", tlb_vpage, 0);
        step();
        rst_n = 1'b1;

        // Table of single translations.
        for (int i = 0; i < 7; i++) begin
            clear_tlb();
            if (vecs[i].pre_valid) begin
                tlb_v[vecs[i].pre_vp]  = 1'b1;
                tlb_pp[vecs[i].pre_vp] = vecs[i].pre_pp;
                tlb_ex[vecs[i].pre_vp] = vecs[i].pre_ex;
            end
            run_txn(vecs[i].vaddr, lat, pa, exc, fills, fvp, fpp, rdy);
            check($sformatf("v%0d req_ready", i), rdy, 1);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d paddr", i), pa, vecs[i].exp_paddr);
            check($sformatf("v%0d exception", i), exc, vecs[i].exp_exc);
            check($sformatf("v%0d fills", i), fills, vecs[i].exp_fills);
            if (vecs[i].exp_fills > 0) begin
                check($sformatf("v%0d fill_vpage", i), fvp, vecs[i].exp_fvp);
                check($sformatf("v%0d fill_ppage", i), fpp, vecs[i].exp_fpp);
            end
        end

        // Flush during the walk: idle at cycle 4, no fill, no response.
        clear_tlb();
        saw_fill = 0;
        saw_resp = 0;
        present(16'h9000);
        for (int c = 1; c <= 10; c++) begin
            step();
            req_valid = 1'b0;
            flush = (c == 3);
            @(negedge clk);
            saw_fill |= fill_valid;
            saw_resp |= resp_valid;
            if (c == 3) check("flush walk state", {req_ready, tlb_valid}, 2'b00);
            if (c == 4) begin
                check("flush idle req_ready", req_ready, 1);
                check("flush idle tlb_valid", tlb_valid, 0);
            end
        end
        flush = 1'b0;
        check("flush walk no fill", saw_fill, 0);
        check("flush walk no resp", saw_resp, 0);

        // Flush in the fill cycle suppresses fill_valid and the response.
        saw_resp = 0;
        present(16'h7123);
        for (int c = 1; c <= 10; c++) begin
            step();
            req_valid = 1'b0;
            flush = (c == 6);
            @(negedge clk);
            saw_resp |= resp_valid;
            if (c == 6) check("flush fill suppressed", fill_valid, 0);
            if (c == 7) check("flush fill idle", req_ready, 1);
        end
        flush = 1'b0;
        check("flush fill no resp", saw_resp, 0);

        // Back-pressured hit: response held stable, flush ignored in RESP.
        clear_tlb();
        tlb_v[5]  = 1'b1;
        tlb_pp[5] = 4'h6;
        resp_ready = 1'b0;
        present(16'h5ABC);
        for (int c = 1; c <= 8; c++) begin
            step();
            req_valid = 1'b0;
            flush = (c == 4);
            resp_ready = (c >= 7);
            @(negedge clk);
            if (c == 1) begin
                check("hold lookup tlb_valid", tlb_valid, 1);
                check("hold lookup tlb_vpage", tlb_vpage, 4'h5);
            end
            if (c >= 2 && c <= 7) begin
                check($sformatf("hold c%0d resp_valid", c), resp_valid, 1);
                check($sformatf("hold c%0d paddr", c), resp_paddr, 16'h6ABC);
                check($sformatf("hold c%0d req_ready", c), req_ready, 0);
            end
            if (c == 8) begin
                check("hold release req_ready", req_ready, 1);
                check("hold release resp_valid", resp_valid, 0);
            end
        end
        flush = 1'b0;
        resp_ready = 1'b1;

        // Asynchronous reset in the middle of a walk.
        clear_tlb();
        present(16'h7123);
        for (int c = 1; c <= 3; c++) begin
            step();
            req_valid = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst req_ready", req_ready, 1);
        check("async rst tlb_valid", tlb_valid, 0);
        check("async rst fill_valid", fill_valid, 0);
        check("async rst resp_valid", resp_valid, 0);
        check("async rst resp_paddr", resp_paddr, 0);
        check("async rst tlb_vpage", tlb_vpage, 0);
        step();
        step();
        rst_n = 1'b1;
        saw_fill = 0;
        saw_resp = 0;
        rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            @(negedge clk);
            saw_fill |= fill_valid;
            saw_resp |= resp_valid;
            rdy &= req_ready;
        end
        check("post rst no fill", saw_fill, 0);
        check("post rst no resp", saw_resp, 0);
        check("post rst req_ready", rdy, 1);

        // TLB drops fills: the controller keeps re-walking, then is flushed.
        clear_tlb();
        fill_en = 1'b0;
        fills = 0;
        saw_resp = 0;
        fill_c[0] = -1;
        fill_c[1] = -1;
        present(16'h7123);
        for (int c = 1; c <= 16; c++) begin
            step();
            req_valid = 1'b0;
            flush = (c == 15);
            @(negedge clk);
            saw_resp |= resp_valid;
            if (fill_valid) begin
                if (fills < 2) fill_c[fills] = c;
                fills++;
            end
            if (c == 16) check("rewalk flush idle", req_ready, 1);
        end
        flush = 1'b0;
        fill_en = 1'b1;
        check("rewalk fill count", fills, 2);
        check("rewalk first fill cycle", fill_c[0], 6);
        check("rewalk second fill cycle", fill_c[1], 12);
        check("rewalk no resp", saw_resp, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end

endmodule
